// File: rtl/fp16_accum_seq.sv
// -----------------------------------------------------------------------------
// fp16_accum_seq
//
// Sequencing front end for an external combinational fp16 adder. Operands
// arrive over a valid/ready stream and are folded into a running sum, one add
// per element. A vector ends with in_last. Its sum, element count and sticky
// NaN/Inf status are then offered over a second valid/ready handshake. This
// block does no arithmetic: every sum comes from the adder as produced.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; discards any partial sum
//   in_valid    operand valid
//   in_ready    block accepts an operand this cycle (RUN state only)
//   in_data     fp16 operand {sign, exp[4:0], frac[9:0]}
//   in_last     operand closes the current vector
//   add_a       adder operand A  (running sum register)
//   add_b       adder operand B  (latest non-first operand register)
//   add_result  combinational sum returned by the adder
//   out_valid   vector sum available (OUT state)
//   out_ready   consumer accepts the sum
//   out_data    vector sum (running sum register)
//   out_count   elements accepted in the vector, saturating at 2^CNT_W-1
//   out_nan     sticky: an operand or adder result in the vector was NaN
//   out_inf     sticky: an operand or adder result in the vector was +/-Inf
// -----------------------------------------------------------------------------
module fp16_accum_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_inf
);

  // RUN: waiting for operands; ADD: adder result being committed;
  // OUT: vector sum held for the consumer.
  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_ADD = 2'd1,
    S_OUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [15:0]      r_acc;
  logic [15:0]      r_opb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic             r_last_q;
  logic             r_nan;
  logic             r_inf;

  logic             w_accept;
  logic             w_in_nan;
  logic             w_in_inf;
  logic             w_res_nan;
  logic             w_res_inf;
  logic [CNT_W-1:0] w_cnt_next;

  // Exponent all-ones marks a special value: nonzero fraction is NaN,
  // zero fraction is infinity.
  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
  endfunction

  // Ready depends on state alone so the upstream never sees a combinational
  // path from its own valid back to ready.
  assign in_ready   = (r_state == S_RUN);
  assign out_valid  = (r_state == S_OUT);
  assign w_accept   = in_valid & in_ready;

  assign w_in_nan   = is_nan(in_data);
  assign w_in_inf   = is_inf(in_data);
  assign w_res_nan  = is_nan(add_result);
  assign w_res_inf  = is_inf(add_result);

  // The count sticks at its maximum instead of wrapping on long vectors.
  assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // The adder sees the registers directly; its output is only sampled in ADD.
  assign add_a      = r_acc;
  assign add_b      = r_opb;
  assign out_data   = r_acc;
  assign out_count  = r_cnt;
  assign out_nan    = r_nan;
  assign out_inf    = r_inf;

  // NOTE: every register here is written with non-blocking assignments so all
  // of them update together from pre-edge values; blocking assignments would
  // let later statements observe half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_acc    <= 16'h0000;
      r_opb    <= 16'h0000;
      r_cnt    <= '0;
      r_first  <= 1'b1;
      r_last_q <= 1'b0;
      r_nan    <= 1'b0;
      r_inf    <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            r_nan <= r_nan | w_in_nan;
            r_inf <= r_inf | w_in_inf;
            if (r_first) begin
              // First element of a vector bypasses the adder entirely.
              r_acc   <= in_data;
              r_cnt   <= CNT_ONE;
              r_first <= 1'b0;
              if (in_last) begin
                r_state <= S_OUT;
              end
            end else begin
              // Remember whether this element closes the vector; the
              // decision is taken after the add commits.
              r_opb    <= in_data;
              r_last_q <= in_last;
              r_cnt    <= w_cnt_next;
              r_state  <= S_ADD;
            end
          end
        end

        S_ADD: begin
          // NaN results are stored as produced; accumulation carries on.
          r_acc   <= add_result;
          r_nan   <= r_nan | w_res_nan;
          r_inf   <= r_inf | w_res_inf;
          r_state <= r_last_q ? S_OUT : S_RUN;
        end

        S_OUT: begin
          // Sum, count and status stay frozen until the consumer takes them.
          if (out_ready) begin
            r_acc   <= 16'h0000;
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_nan   <= 1'b0;
            r_inf   <= 1'b0;
            r_state <= S_RUN;
          end
        end

        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// -----------------------------------------------------------------------------
// tb_fp16_accum_seq
//
// Drives fp16_accum_seq with directed vectors and a long randomized stream.
// The external adder is modelled with exact integer arithmetic and
// round-to-nearest-even. Outside the ADD cycle the adder output is
// deliberately garbage, since the DUT must ignore it there.
// The reference model keeps each vector as a list of accepted operands and
// derives sum, count and status by folding that list.
// -----------------------------------------------------------------------------
module tb_fp16_accum_seq;

  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_last;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic [15:0]   add_result;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [CW-1:0] out_count;
  logic          out_nan;
  logic          out_inf;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: operands of the open vector, plus timing flags.
  logic [15:0] cur[$];
  logic        m_add_pending;
  logic        m_done;
  logic [15:0] m_opb;
  logic        add_phase;
  logic [15:0] junk;
  logic        rdy_rand;
  logic        rdy_fixed;

  fp16_accum_seq #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_nan    (out_nan),
    .out_inf    (out_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic f_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic f_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
  endfunction

  // fp16 value scaled by 2^24: every finite fp16 is an exact integer here.
  function automatic longint to_fix(input logic [15:0] x);
    longint m;
    if (x[14:10] == 5'd0) m = longint'(x[9:0]);
    else                  m = longint'({1'b1, x[9:0]}) <<< (int'(x[14:10]) - 1);
    return x[15] ? -m : m;
  endfunction

  // Reference fp16 adder: exact sum, then round to nearest even.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    longint s, m, mant, rem, half;
    int     p, e, sh;
    logic   sg;
    if (f_nan(a) || f_nan(b)) return 16'h7E00;
    if (f_inf(a) && f_inf(b)) return (a[15] == b[15]) ? a : 16'h7E00;
    if (f_inf(a)) return a;
    if (f_inf(b)) return b;
    s = to_fix(a) + to_fix(b);
    if (s == 0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
    sg = (s < 0);
    m  = sg ? -s : s;
    if (m < 1024) return {sg, 5'd0, m[9:0]};
    p = 0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    sh   = p - 10;
    e    = sh + 1;
    mant = m >>> sh;
    rem  = m - (mant <<< sh);
    if (sh > 0) begin
      half = longint'(1) <<< (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
    end
    if (mant == 2048) begin
      mant = 1024;
      e++;
    end
    if (e >= 31) return {sg, 5'h1F, 10'h000};
    return {sg, 5'(e), 10'(mant)};
  endfunction

  // Fold the first n operands of the open vector into sum and status.
  function automatic void eval_vec(input int n, output logic [15:0] s,
                                   output logic fn, output logic fi);
    s  = 16'h0000;
    fn = 1'b0;
    fi = 1'b0;
    for (int i = 0; i < n; i++) begin
      fn = fn | f_nan(cur[i]);
      fi = fi | f_inf(cur[i]);
      if (i == 0) begin
        s = cur[i];
      end else begin
        s  = fp16_add(s, cur[i]);
        fn = fn | f_nan(s);
        fi = fi | f_inf(s);
      end
    end
  endfunction

  // External adder: valid only in the cycle the model expects an add.
  assign add_result = add_phase ? fp16_add(add_a, add_b) : junk;

  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  // ------------------------------------------------------ compare process
  always @(negedge clk) begin
    logic [15:0] e_sum;
    logic        e_nan;
    logic        e_inf;
    int          n;
    int          e_cnt;
    if (!rst_n) begin
      cur.delete();
      m_add_pending = 1'b0;
      m_done        = 1'b0;
      m_opb         = 16'h0000;
    end
    add_phase = rst_n && m_add_pending;
    junk      = 16'($urandom);
    n         = m_add_pending ? cur.size() - 1 : cur.size();
    eval_vec(n, e_sum, e_nan, e_inf);
    e_cnt = (cur.size() > CMAX) ? CMAX : cur.size();
    check("in_ready",  32'(in_ready),  32'(!m_add_pending && !m_done));
    check("out_valid", 32'(out_valid), 32'(m_done && !m_add_pending));
    check("add_a",     32'(add_a),     32'(e_sum));
    check("out_data",  32'(out_data),  32'(e_sum));
    check("add_b",     32'(add_b),     32'(m_opb));
    check("out_count", 32'(out_count), 32'(e_cnt));
    if (m_done && !m_add_pending) begin
      check("out_nan", 32'(out_nan), 32'(e_nan));
      check("out_inf", 32'(out_inf), 32'(e_inf));
    end
    // Advance the model to what the coming rising edge does.
    if (rst_n) begin
      if (m_add_pending) begin
        m_add_pending = 1'b0;
      end else if (m_done) begin
        if (out_ready) begin
          m_done = 1'b0;
          cur.delete();
        end
      end else if (in_valid) begin
        cur.push_back(in_data);
        if (cur.size() > 1) begin
          m_add_pending = 1'b1;
          m_opb         = in_data;
        end
        if (in_last) m_done = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- driving
  // All driver tasks start and end just after a rising edge.
  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic l, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    realign();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Ends on the falling edge where out_valid is seen.
  task automatic wait_valid(output int waited);
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    case ($urandom_range(0, 31))
      0:       v = 16'h7C00;
      1:       v = 16'hFC00;
      2:       v = 16'h7E00;
      3:       v = 16'h7BFF;
      4:       v = 16'h0000;
      default: begin
        v[15]    = 1'($urandom_range(0, 1));
        v[14:10] = 5'($urandom_range(8, 22));
        v[9:0]   = 10'($urandom);
      end
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int len;
    int busy;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_data       = 16'h0000;
    in_last       = 1'b0;
    rdy_rand      = 1'b0;
    rdy_fixed     = 1'b1;
    out_ready     = 1'b0;
    add_phase     = 1'b0;
    junk          = 16'h0000;
    m_add_pending = 1'b0;
    m_done        = 1'b0;
    m_opb         = 16'h0000;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    realign();

    // {1.0, 2.0}: ready 1,1,0 then sum 3.0 one cycle after ADD.
    push(16'h3C00, 1'b0, w);
    check("t1_ready_e0", 32'(w), 32'd0);
    push(16'h4000, 1'b1, w);
    check("t1_ready_e1", 32'(w), 32'd0);
    @(negedge clk);
    check("t1_ready_add", 32'(in_ready), 32'd0);
    wait_valid(w);
    check("t1_latency", 32'(w), 32'd0);
    check("t1_sum",     32'(out_data),  32'h4200);
    check("t1_count",   32'(out_count), 32'd2);
    check("t1_flags",   32'({out_nan, out_inf}), 32'd0);
    realign();

    // {1.0, 2.0, 0.5}: adder operands, then sum 3.5.
    push(16'h3C00, 1'b0, w);
    push(16'h4000, 1'b0, w);
    @(negedge clk);
    check("t2_add_a0", 32'(add_a), 32'h3C00);
    check("t2_add_b0", 32'(add_b), 32'h4000);
    realign();
    push(16'h3800, 1'b1, w);
    @(negedge clk);
    check("t2_add_a1", 32'(add_a), 32'h4200);
    check("t2_add_b1", 32'(add_b), 32'h3800);
    wait_valid(w);
    check("t2_sum",   32'(out_data),  32'h4300);
    check("t2_count", 32'(out_count), 32'd3);
    realign();

    // Single element -1.0: valid next cycle, adder output ignored.
    push(16'hBC00, 1'b1, w);
    wait_valid(w);
    check("t3_latency", 32'(w), 32'd0);
    check("t3_sum",     32'(out_data),  32'hBC00);
    check("t3_count",   32'(out_count), 32'd1);
    realign();

    // Backpressure with a pending operand waiting upstream.
    rdy_fixed = 1'b0;
    push(16'h3C00, 1'b0, w);
    push(16'h3C00, 1'b1, w);
    in_valid = 1'b1;
    in_data  = 16'h4400;
    in_last  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_ready", 32'(in_ready),  32'd0);
      check("t4_stall_valid", 32'(out_valid), 32'd1);
      check("t4_stall_sum",   32'(out_data),  32'h4000);
      check("t4_stall_count", 32'(out_count), 32'd2);
      check("t4_stall_flags", 32'({out_nan, out_inf}), 32'd0);
    end
    realign();
    rdy_fixed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_cleared_acc",   32'(out_data),  32'h0);
    check("t4_cleared_count", 32'(out_count), 32'd0);
    realign();
    push(16'h3C00, 1'b1, w);
    wait_valid(w);
    check("t4_next_sum",   32'(out_data),  32'h4500);
    check("t4_next_count", 32'(out_count), 32'd2);
    realign();

    // Overflow to infinity, then status clears after the handshake.
    push(16'h7BFF, 1'b0, w);
    push(16'h7BFF, 1'b1, w);
    wait_valid(w);
    check("t5_inf_sum", 32'(out_data), 32'h7C00);
    check("t5_inf_flag", 32'({out_nan, out_inf}), 32'b01);
    realign();
    @(negedge clk);
    check("t5_inf_clear", 32'({out_nan, out_inf}), 32'd0);
    realign();
    push(16'h3C00, 1'b0, w);
    push(16'h7E00, 1'b1, w);
    wait_valid(w);
    check("t5_nan_flag", 32'(out_nan), 32'd1);
    realign();
    @(negedge clk);
    check("t5_nan_clear", 32'({out_nan, out_inf}), 32'd0);
    realign();

    // Reset mid-vector after 2.0 is accepted.
    push(16'h4000, 1'b0, w);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(in_ready),  32'd1);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data",  32'(out_data),  32'h0);
    check("t6_rst_add_a", 32'(add_a),     32'h0);
    check("t6_rst_add_b", 32'(add_b),     32'h0);
    check("t6_rst_count", 32'(out_count), 32'd0);
    check("t6_rst_flags", 32'({out_nan, out_inf}), 32'd0);
    realign();
    realign();
    rst_n = 1'b1;
    push(16'h3800, 1'b1, w);
    wait_valid(w);
    check("t6_sum",   32'(out_data),  32'h3800);
    check("t6_count", 32'(out_count), 32'd1);
    realign();

    // Reset while a sum is held in OUT discards it.
    rdy_fixed = 1'b0;
    push(16'h4000, 1'b1, w);
    wait_valid(w);
    realign();
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_data",  32'(out_data),  32'h0);
    realign();
    realign();
    rst_n     = 1'b1;
    rdy_fixed = 1'b1;

    // Randomized stream; long vectors exercise count saturation.
    rdy_rand = 1'b1;
    for (int v = 0; v < 150; v++) begin
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 11) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) realign();
        push(rand_op(), (i == len - 1), w);
      end
    end

    busy = 1;
    for (int i = 0; i < 100 && busy != 0; i++) begin
      @(negedge clk);
      busy = (m_done || m_add_pending) ? 1 : 0;
    end
    check("drain", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fp16_accum_seq.md
# fp16_accum_seq

Sequential accumulation controller that sits directly upstream of the team's combinational fp16 adder. It accepts a stream of fp16 operands (products from the MAC array) over a valid/ready handshake and feeds the adder one add per element. It registers each adder result back into a running sum and emits one fp16 sum per vector, delimited by `in_last`, with sticky NaN/Inf status.

## Interface
- `CNT_W`, default 16: width of the per-vector element counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept an operand this cycle.
- `in_data`  in  16  fp16 operand (sign[15], exp[14:10], frac[9:0]).
- `in_last`  in  1  operand is the final element of the vector.
- `add_a`  out  16  adder operand A; always equals the accumulator register.
- `add_b`  out  16  adder operand B; always equals the operand register.
- `add_result`  in  16  combinational sum from the fp16 adder.
- `out_valid`  out  1  vector sum available.
- `out_ready`  in  1  consumer accepts the sum.
- `out_data`  out  16  vector sum; always equals the accumulator register.
- `out_count`  out  CNT_W  number of elements accepted in the vector, saturating.
- `out_nan`  out  1  sticky: any operand or adder result in the vector was NaN (exp=31, frac≠0).
- `out_inf`  out  1  sticky: any adder result or operand was ±Inf (exp=31, frac=0).

## Operation
- State register with three states: RUN, ADD, OUT. Registers are `acc[15:0]`, `opb[15:0]`, `cnt`, `first`, `last_q`, `nan_q` and `inf_q`.
- `in_ready` = (state==RUN). `out_valid` = (state==OUT).
- An operand is accepted when `in_valid & in_ready`.
- **RUN, accept with `first=1`** (first element of a vector):
  - The adder is bypassed: `acc<=in_data`, `cnt<=1`, `first<=0`.
  - Flags are updated from `in_data`.
  - If `in_last`, go to OUT; otherwise stay in RUN.
- **RUN, accept with `first=0`:**
  - `opb<=in_data`, `last_q<=in_last`, `cnt<=cnt+1` saturating at 2^CNT_W−1.
  - Flags are updated from `in_data`.
  - Go to ADD.
- **RUN, no accept:** hold all state.
- **ADD:**
  - `acc<=add_result`.
  - Flags are updated from `add_result`.
  - If `last_q`, go to OUT; otherwise go to RUN.
  - No operand is accepted in this state.
- **OUT:**
  - Hold `acc`, `cnt` and flags stable while `out_ready=0`.
  - On `out_ready=1`: `acc<=16'h0000`, `cnt<=0`, `first<=1`, flags cleared, go to RUN.
- Flag update rules:
  - `nan_q |= (exp==31 & frac!=0)`.
  - `inf_q |= (exp==31 & frac==0)`.
  - A NaN result does not stop accumulation; the adder's output is stored as produced.
- No rounding or normalisation is done here; arithmetic is entirely the adder's. The block only sequences operands and results.
- `add_a`/`add_b` are driven continuously from registers. The adder output is sampled only in ADD.

## Timing
- Reset (`rst_n` low, asynchronous) sets:
  - state=RUN, `first=1`, `acc=0`, `opb=0`, `cnt=0`, `last_q=0`, flags=0.
  - Outputs: `in_ready=1`, `out_valid=0`, `out_data=16'h0000`, `add_a=add_b=16'h0000`, `out_count=0`, `out_nan=out_inf=0`.
- Reset asserted mid-vector or in OUT discards the partial or unconsumed sum. The first accept after deassertion starts a new vector.
- Throughput: the first element takes 1 cycle; each subsequent element takes 2 cycles (accept, then ADD).
- Latency:
  - Last element accepted at edge t, vector length ≥2: commit at edge t+1, `out_valid` high from t+1 until handshake.
  - Single-element vector (first and last together): `out_valid` high from edge t.
- The OUT handshake edge returns to RUN. `in_ready` is high the following cycle, so there is one bubble between vectors.
- `in_ready` depends only on state, never combinationally on `in_valid`. `out_valid` never drops without `out_ready`.
- `in_last` on a non-accepted cycle is ignored.

## Test plan
- Reset, then vector {0x3C00, 0x4000} with `in_last` on the second element, `out_ready=1`:
  - `in_ready` pattern is 1,1,0,… .
  - `out_valid` 1 cycle after the ADD cycle.
  - `out_data=0x4200`, `out_count=2`, flags 0.
- Vector {0x3C00, 0x4000, 0x3800}:
  - `add_a`/`add_b` equal 0x3C00/0x4000, then 0x4200/0x3800.
  - Sum 0x4300, `out_count=3`.
- Single-element vector 0xBC00 with `in_last`:
  - `out_valid` on the next cycle, `out_data=0xBC00`, `out_count=1`.
  - The adder output is ignored.
- Backpressure: hold `out_ready=0` for 5 cycles with `in_valid=1`:
  - `in_ready=0` throughout; `out_data`, `out_count` and flags are stable.
  - On release, the accumulator reads 0 and the next vector sums independently.
- Status:
  - Vector {0x7BFF, 0x7BFF}: `out_data=0x7C00`, `out_inf=1`.
  - Vector {0x3C00, 0x7E00}: `out_nan=1`.
  - Both flags clear after the handshake.
- Reset mid-vector, after 0x4000 is accepted:
  - All outputs return to their reset values.
  - Vector {0x3800} then gives `out_data=0x3800`, `out_count=1`.
